// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU
// one operation per clock: shift-add multiply and restoring division.
module alu_muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_opr,
  output logic [XLEN-1:0] alu_operand1,
  output logic [XLEN-1:0] alu_operand2,
  input  logic [XLEN-1:0] alu_result
);

  // state | meaning
  // IDLE  | waiting for start; ALU free for the pipeline
  // ITER  | one multiply bit: hi + (lo[0] ? mcand : 0), then shift
  // CMP   | divide: shift remainder in, compare against divisor (SLTU)
  // SUB   | divide: conditional subtract, set quotient bit
  // DONE  | one-cycle done pulse, result valid
  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_CMP,
    S_SUB,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

  state_t state, next_state;

  logic [1:0]      op_q;
  logic [CNT_W-1:0] cnt;
  // acc holds hi (multiply) or R (divide); shf holds lo or Q; opd holds mcand or D
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] shf;
  logic [XLEN-1:0] opd;
  logic            ge_q;

  logic            last;
  logic            carry;
  logic [XLEN-1:0] rs_shift;
  logic [XLEN-1:0] mul_hi_nxt;
  logic [XLEN-1:0] mul_lo_nxt;
  logic [XLEN-1:0] div_rem_nxt;
  logic [XLEN-1:0] div_quo_nxt;

  assign last     = (cnt == CNT_W'(XLEN - 1));
  assign rs_shift = {acc[XLEN-2:0], shf[XLEN-1]};

  // Carry out of the ALU add recovered from operand and sum MSBs.
  assign carry = (alu_operand1[XLEN-1] & alu_operand2[XLEN-1]) |
                 ((alu_operand1[XLEN-1] ^ alu_operand2[XLEN-1]) & ~alu_result[XLEN-1]);

  assign mul_hi_nxt  = {carry, alu_result[XLEN-1:1]};
  assign mul_lo_nxt  = {alu_result[0], shf[XLEN-1:1]};
  assign div_rem_nxt = ge_q ? alu_result : acc;
  assign div_quo_nxt = {shf[XLEN-1:1], shf[0] | ge_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    busy         = 1'b0;
    done         = 1'b0;
    alu_opr      = ALU_ADD;
    alu_operand1 = '0;
    alu_operand2 = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!op[1])          next_state = S_ITER;
          else if (rs2 == '0)  next_state = S_DONE;
          else                 next_state = S_CMP;
        end
      end
      S_ITER: begin
        busy         = 1'b1;
        alu_operand1 = acc;
        alu_operand2 = shf[0] ? opd : '0;
        if (last) next_state = S_DONE;
      end
      S_CMP: begin
        busy         = 1'b1;
        alu_opr      = ALU_SLTU;
        alu_operand1 = rs_shift;
        alu_operand2 = opd;
        next_state   = S_SUB;
      end
      S_SUB: begin
        busy         = 1'b1;
        alu_opr      = ALU_SUB;
        alu_operand1 = acc;
        alu_operand2 = opd;
        next_state   = last ? S_DONE : S_CMP;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      shf    <= '0;
      opd    <= '0;
      ge_q   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            cnt  <= '0;
            acc  <= '0;
            shf  <= rs1;
            opd  <= rs2;
            // Divide by zero skips the datapath entirely.
            if (op[1] && (rs2 == '0))
              result <= (op == OP_DIVU) ? '1 : rs1;
          end
        end
        S_ITER: begin
          acc <= mul_hi_nxt;
          shf <= mul_lo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last)
            result <= (op_q == OP_MUL) ? mul_lo_nxt : mul_hi_nxt;
        end
        S_CMP: begin
          acc  <= rs_shift;
          shf  <= {shf[XLEN-2:0], 1'b0};
          ge_q <= ~alu_result[0];
        end
        S_SUB: begin
          acc <= div_rem_nxt;
          shf <= div_quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last)
            result <= (op_q == OP_DIVU) ? div_quo_nxt : div_rem_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
